multi_reg_sequencer: RTL and testbench

//  Sequences Thumb PUSH/POP register lists for the M0 core: walks a 10-bit list, issues one

---
 rtl/multi_reg_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_multi_reg_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_reg_sequencer.sv
// Thumb PUSH/POP multi-register sequencer: walks the register list lowest-first, issues one
// word access per register, writes loaded registers back, then updates SP (and PC on POP).
module multi_reg_sequencer #(
    parameter logic [3:0] SP_IDX = 4'd13,
    parameter int         WORD   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      push_pop,
    input  logic [9:0]      list_in,
    input  logic [WORD-1:0] sp_in,
    output logic [3:0]      rd_addr,
    input  logic [WORD-1:0] rd_data,
    output logic [3:0]      w_reg_addr,
    output logic            w_reg_en,
    output logic [WORD-1:0] w_reg_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata,
    output logic [9:0]      list_remaining,
    output logic            busy,
    output logic            done,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_SP_WB = 3'd3,
        S_PC_WB = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            push_q, push_d;
    logic [9:0]      list_q, list_d;
    logic [WORD-1:0] sp_q, sp_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] new_sp_q, new_sp_d;
    logic            pc_pend_q, pc_pend_d;
    logic [WORD-1:0] pc_data_q, pc_data_d;
    logic            wb_pend_q, wb_pend_d;
    logic [3:0]      wb_addr_q, wb_addr_d;
    logic [WORD-1:0] wb_data_q, wb_data_d;

    logic [3:0]      cur_bit;
    logic [3:0]      cur_idx;
    logic [3:0]      list_cnt;
    logic [WORD-1:0] byte_off;
    logic [9:0]      list_next;
    logic            start_ok;
    logic [9:0]      masked_list;

    // Lowest set bit of the remaining list, mapped to the architectural register index.
    always_comb begin
        cur_bit = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (list_q[i]) cur_bit = 4'(i);
        end
        if (cur_bit == 4'd8)      cur_idx = 4'd14;
        else if (cur_bit == 4'd9) cur_idx = 4'd15;
        else                      cur_idx = cur_bit;
    end

    always_comb begin
        list_cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            list_cnt = list_cnt + {3'd0, list_q[i]};
        end
        byte_off = {{(WORD-6){1'b0}}, list_cnt, 2'b00};
    end

    assign list_next   = list_q & (list_q - 10'd1);
    assign start_ok    = start && ((push_pop == 2'b01) || (push_pop == 2'b10));
    assign masked_list = (push_pop == 2'b01) ? (list_in & 10'h1FF) : (list_in & 10'h2FF);

    always_comb begin
        state_d   = state_q;
        push_d    = push_q;
        list_d    = list_q;
        sp_d      = sp_q;
        addr_d    = addr_q;
        new_sp_d  = new_sp_q;
        pc_pend_d = pc_pend_q;
        pc_data_d = pc_data_q;
        wb_pend_d = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_SETUP;
                    push_d    = (push_pop == 2'b01);
                    list_d    = masked_list;
                    sp_d      = sp_in;
                    pc_pend_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (push_q) begin
                    addr_d   = sp_q - byte_off;
                    new_sp_d = sp_q - byte_off;
                end else begin
                    addr_d   = sp_q;
                    new_sp_d = sp_q + byte_off;
                end
                state_d = (list_q == 10'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                if (mem_ack) begin
                    list_d = list_next;
                    addr_d = addr_q + WORD'(4);
                    if (!push_q) begin
                        if (cur_idx == 4'd15) begin
                            pc_pend_d = 1'b1;
                            pc_data_d = mem_rdata;
                        end else begin
                            wb_pend_d = 1'b1;
                            wb_addr_d = cur_idx;
                            wb_data_d = mem_rdata;
                        end
                    end
                    if (list_next == 10'd0) state_d = S_SP_WB;
                end
            end
            // A load write-back still pending owns the write port; SP waits one cycle.
            S_SP_WB: begin
                if (!wb_pend_q) state_d = pc_pend_q ? S_PC_WB : S_DONE;
            end
            S_PC_WB: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            push_q    <= 1'b0;
            list_q    <= '0;
            sp_q      <= '0;
            addr_q    <= '0;
            new_sp_q  <= '0;
            pc_pend_q <= 1'b0;
            pc_data_q <= '0;
            wb_pend_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            push_q    <= push_d;
            list_q    <= list_d;
            sp_q      <= sp_d;
            addr_q    <= addr_d;
            new_sp_q  <= new_sp_d;
            pc_pend_q <= pc_pend_d;
            pc_data_q <= pc_data_d;
            wb_pend_q <= wb_pend_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        w_reg_en   = 1'b0;
        w_reg_addr = 4'd0;
        w_reg_in   = '0;
        if (wb_pend_q) begin
            w_reg_en   = 1'b1;
            w_reg_addr = wb_addr_q;
            w_reg_in   = wb_data_q;
        end else if (state_q == S_SP_WB) begin
            w_reg_en   = 1'b1;
            w_reg_addr = SP_IDX;
            w_reg_in   = new_sp_q;
        end else if (state_q == S_PC_WB) begin
            w_reg_en   = 1'b1;
            w_reg_addr = 4'd15;
            w_reg_in   = pc_data_q;
        end
    end

    assign mem_req        = (state_q == S_XFER);
    assign mem_we         = mem_req && push_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = mem_we ? rd_data : '0;
    assign rd_addr        = cur_idx;
    assign list_remaining = list_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Directed bench for multi_reg_sequencer: register bank and memory models, write/access logs
// compared against hand-computed expected queues.
module tb_multi_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  push_pop;
    logic [9:0]  list_in;
    logic [31:0] sp_in;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  w_reg_addr;
    logic        w_reg_en;
    logic [31:0] w_reg_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [9:0]  list_remaining;
    logic        busy, done;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    multi_reg_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .push_pop(push_pop), .list_in(list_in),
        .sp_in(sp_in), .rd_addr(rd_addr), .rd_data(rd_data), .w_reg_addr(w_reg_addr),
        .w_reg_en(w_reg_en), .w_reg_in(w_reg_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .list_remaining(list_remaining), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    logic [31:0] regs [16];
    logic [31:0] load_mem [8];
    logic [2:0]  load_idx;
    int          ack_delay, wait_cnt;
    logic        mem_ack_force, log_clr;
    logic [31:0] watch_addr;

    assign rd_data   = regs[rd_addr];
    assign mem_rdata = load_mem[load_idx];
    assign mem_ack   = mem_ack_force | (mem_req & (wait_cnt == ack_delay));

    logic [35:0] wr_log[$];
    logic [64:0] acc_log[$];
    logic [35:0] exp_wr_q[$];
    logic [64:0] exp_acc_q[$];
    int          req_cycles, addr_hits, done_cnt;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (log_clr) begin
            wr_log.delete();
            acc_log.delete();
            req_cycles <= 0;
            addr_hits  <= 0;
            done_cnt   <= 0;
            load_idx   <= 3'd0;
            wait_cnt   <= 0;
        end else begin
            if (w_reg_en) wr_log.push_back({w_reg_addr, w_reg_in});
            if (mem_req) begin
                req_cycles <= req_cycles + 1;
                if (mem_addr == watch_addr) addr_hits <= addr_hits + 1;
                if (mem_ack) begin
                    acc_log.push_back({mem_we, mem_addr, mem_wdata});
                    load_idx <= load_idx + 3'd1;
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_wr_count"}, 65'(wr_log.size()), 65'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 65'(wr_log[i]), 65'(exp_wr_q[i]));
        check({tag, "_acc_count"}, 65'(acc_log.size()), 65'(exp_acc_q.size()));
        for (int i = 0; i < exp_acc_q.size() && i < acc_log.size(); i++)
            check($sformatf("%s_acc%0d", tag, i), acc_log[i], exp_acc_q[i]);
    endtask

    task automatic clear_logs();
        exp_wr_q.delete();
        exp_acc_q.delete();
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] pp, input logic [9:0] l, input logic [31:0] s,
                          output int lat);
        @(negedge clk);
        start = 1'b1; push_pop = pp; list_in = l; sp_in = s;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 100);
        check("op_done_seen", 65'(done), 65'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; push_pop = 2'b00; list_in = '0; sp_in = '0;
        mem_ack_force = 1'b0; ack_delay = 0; log_clr = 1'b0; watch_addr = '0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h5000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) load_mem[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_done", 65'(done), 65'd0);
        check("rst_mem_req", 65'(mem_req), 65'd0);
        check("rst_mem_we", 65'(mem_we), 65'd0);
        check("rst_w_reg_en", 65'(w_reg_en), 65'd0);
        check("rst_mem_addr", 65'(mem_addr), 65'd0);
        check("rst_mem_wdata", 65'(mem_wdata), 65'd0);
        check("rst_list_rem", 65'(list_remaining), 65'd0);
        check("rst_rd_addr", 65'(rd_addr), 65'd0);
        check("rst_w_reg_addr", 65'(w_reg_addr), 65'd0);
        check("rst_w_reg_in", 65'(w_reg_in), 65'd0);
        check("rst_state", 65'(state_dbg), 65'd0);
        rst = 1'b0;

        // PUSH {r0,r2,LR}, sp=0x200, zero-wait memory
        regs[0] = 32'h1111_0000; regs[2] = 32'h2222_0002; regs[14] = 32'hEEEE_000E;
        clear_logs();
        ack_delay = 0;
        exp_acc_q.push_back({1'b1, 32'h0000_01F4, 32'h1111_0000});
        exp_acc_q.push_back({1'b1, 32'h0000_01F8, 32'h2222_0002});
        exp_acc_q.push_back({1'b1, 32'h0000_01FC, 32'hEEEE_000E});
        exp_wr_q.push_back({4'd13, 32'h0000_01F4});
        run_op(2'b01, 10'h105, 32'h0000_0200, lat);
        check("push3_latency", 65'(lat), 65'd6);
        @(negedge clk);
        check("push3_busy_after", 65'(busy), 65'd0);
        check_logs("push3");

        // POP {r1,r7,PC}, sp=0x1F4
        clear_logs();
        load_mem[0] = 32'h0000_000A; load_mem[1] = 32'h0000_000B; load_mem[2] = 32'h0000_000C;
        exp_acc_q.push_back({1'b0, 32'h0000_01F4, 32'h0});
        exp_acc_q.push_back({1'b0, 32'h0000_01F8, 32'h0});
        exp_acc_q.push_back({1'b0, 32'h0000_01FC, 32'h0});
        exp_wr_q.push_back({4'd1, 32'h0000_000A});
        exp_wr_q.push_back({4'd7, 32'h0000_000B});
        exp_wr_q.push_back({4'd13, 32'h0000_0200});
        exp_wr_q.push_back({4'd15, 32'h0000_000C});
        run_op(2'b10, 10'h282, 32'h0000_01F4, lat);
        check("pop_pc_latency", 65'(lat), 65'd7);
        repeat (3) @(negedge clk);
        check("pop_pc_done_once", 65'(done_cnt), 65'd1);
        check_logs("pop_pc");

        // POP {r3} with three wait cycles
        clear_logs();
        ack_delay = 3;
        watch_addr = 32'h0000_0300;
        load_mem[0] = 32'hDEAD_BEEF;
        exp_acc_q.push_back({1'b0, 32'h0000_0300, 32'h0});
        exp_wr_q.push_back({4'd3, 32'hDEAD_BEEF});
        exp_wr_q.push_back({4'd13, 32'h0000_0304});
        run_op(2'b10, 10'h008, 32'h0000_0300, lat);
        @(negedge clk);
        check("pop_wait_req_cycles", 65'(req_cycles), 65'd4);
        check("pop_wait_addr_stable", 65'(addr_hits), 65'd4);
        check_logs("pop_wait");

        // PUSH of PC only masks to an empty list
        clear_logs();
        ack_delay = 0;
        run_op(2'b01, 10'h200, 32'h0000_0400, lat);
        check("empty_latency", 65'(lat), 65'd2);
        @(negedge clk);
        check("empty_req_cycles", 65'(req_cycles), 65'd0);
        check("empty_done_cnt", 65'(done_cnt), 65'd1);
        check_logs("empty");

        // Illegal push_pop encodings in IDLE
        clear_logs();
        @(negedge clk);
        start = 1'b1; push_pop = 2'b11; list_in = 10'h3FF; sp_in = 32'h0000_0800;
        @(negedge clk);
        push_pop = 2'b00;
        @(negedge clk);
        start = 1'b0;
        check("ill_busy", 65'(busy), 65'd0);
        check("ill_list_rem", 65'(list_remaining), 65'd0);
        repeat (2) @(negedge clk);
        check("ill_req_cycles", 65'(req_cycles), 65'd0);
        check("ill_state", 65'(state_dbg), 65'd0);
        check_logs("ill");

        // Start while busy is ignored; a stray ack during SETUP is ignored
        clear_logs();
        ack_delay = 2;
        regs[0] = 32'hCAFE_0000;
        exp_acc_q.push_back({1'b1, 32'h0000_00FC, 32'hCAFE_0000});
        exp_wr_q.push_back({4'd13, 32'h0000_00FC});
        @(negedge clk);
        start = 1'b1; push_pop = 2'b01; list_in = 10'h001; sp_in = 32'h0000_0100;
        @(negedge clk);
        push_pop = 2'b10; list_in = 10'h0FF; sp_in = 32'h0000_0999;
        mem_ack_force = 1'b1;
        check("busy_setup_list", 65'(list_remaining), 65'h001);
        @(negedge clk);
        start = 1'b0; mem_ack_force = 1'b0;
        check("busy_xfer_addr", 65'(mem_addr), 65'h0FC);
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        check("busy_done_seen", 65'(done), 65'd1);
        repeat (2) @(negedge clk);
        check("busy_idle_after", 65'(busy), 65'd0);
        check("busy_done_cnt", 65'(done_cnt), 65'd1);
        check_logs("busy");

        // Reset in the middle of a 4-register POP
        clear_logs();
        ack_delay = 1;
        load_mem[0] = 32'h10; load_mem[1] = 32'h11; load_mem[2] = 32'h12; load_mem[3] = 32'h13;
        exp_acc_q.push_back({1'b0, 32'h0000_0500, 32'h0});
        exp_wr_q.push_back({4'd0, 32'h0000_0010});
        @(negedge clk);
        start = 1'b1; push_pop = 2'b10; list_in = 10'h00F; sp_in = 32'h0000_0500;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_req", 65'(mem_req), 65'd1);
        check("mid_addr0", 65'(mem_addr), 65'h500);
        @(negedge clk);
        @(negedge clk);
        check("mid_wb_en", 65'(w_reg_en), 65'd1);
        check("mid_wb_data", 65'({w_reg_addr, w_reg_in}), 65'h0_0000_0010);
        check("mid_list_rem", 65'(list_remaining), 65'h00E);
        check("mid_addr1", 65'(mem_addr), 65'h504);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 65'(busy), 65'd0);
        check("mid_rst_req", 65'(mem_req), 65'd0);
        check("mid_rst_wen", 65'(w_reg_en), 65'd0);
        check("mid_rst_list", 65'(list_remaining), 65'd0);
        check("mid_rst_addr", 65'(mem_addr), 65'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_req_cycles", 65'(req_cycles), 65'd3);
        check("mid_done_cnt", 65'(done_cnt), 65'd0);
        check_logs("mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
